// File: rtl/gpr_file_scoreboard.sv
// gpr_file_scoreboard
// General-purpose register file with PC register and per-register
// pending-write scoreboard for the pipelined core.
//
// Two combinational read ports return register data plus a busy flag. Issue
// reserves a destination by bumping its pending counter. Writeback writes the
// data and releases one reservation. Flush drops every reservation.
//
// Parameters:
//   XLEN      data width of registers and PC
//   NUM_REGS  32 (RV32I) or 16 (RV32E)
//   PEND_W    pending counter width (max 2^PEND_W-1 outstanding writers)
//   BYPASS    1 = writeback data forwarded to the read ports in the same cycle
//   RESET_PC  PC value after reset
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   rs1_index/rs1_data/rs1_busy   read port 1
//   rs2_index/rs2_data/rs2_busy   read port 2
//   issue_valid/issue_rd          reserve a destination register
//   issue_ready                   issue_rd counter not saturated
//   wb_valid/wb_index/wb_data     writeback
//   flush                         clear all pending counters
//   illegal_index                 an in-use index is >= NUM_REGS
//   pc_read_data                  current PC
//   pc_write_data/pc_write_enable PC load
//
// Optional build macro GPR_DEBUG_PORT_EN adds:
//   dbg_index in 5, dbg_data out XLEN (raw content, no bypass),
//   dbg_pending out PEND_W (that register's counter).

module gpr_file_scoreboard #(
    parameter int              XLEN     = 32,
    parameter int              NUM_REGS = 32,
    parameter int              PEND_W   = 2,
    parameter int              BYPASS   = 1,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        rs1_index,
    output logic [XLEN-1:0]   rs1_data,
    output logic              rs1_busy,
    input  logic [4:0]        rs2_index,
    output logic [XLEN-1:0]   rs2_data,
    output logic              rs2_busy,
    input  logic              issue_valid,
    input  logic [4:0]        issue_rd,
    output logic              issue_ready,
    input  logic              wb_valid,
    input  logic [4:0]        wb_index,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              illegal_index,
    output logic [XLEN-1:0]   pc_read_data,
    input  logic [XLEN-1:0]   pc_write_data,
    input  logic              pc_write_enable
`ifdef GPR_DEBUG_PORT_EN
    ,
    input  logic [4:0]        dbg_index,
    output logic [XLEN-1:0]   dbg_data,
    output logic [PEND_W-1:0] dbg_pending
`endif
);

    localparam logic [5:0]        NREGS6  = 6'(NUM_REGS);
    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    function automatic logic in_range(input logic [4:0] idx);
        return {1'b0, idx} < NREGS6;
    endfunction

    // Full 32-entry views. Entries for x0 and for indices beyond NUM_REGS are
    // tied to zero, so every 5-bit index can be used directly and naturally
    // reads as 0 data / 0 pending.
    logic [XLEN-1:0]   reg_view [32];
    logic [PEND_W-1:0] cnt_view [32];

    logic wb_fire;
    logic issue_fire;
    logic rs1_hit;
    logic rs2_hit;

    assign wb_fire = wb_valid && in_range(wb_index) && (wb_index != 5'd0);

    // A saturated counter can still accept an issue when a writeback to the
    // same register releases a slot in the same cycle.
    assign issue_ready = !((cnt_view[issue_rd] == CNT_MAX) &&
                           !(wb_valid && (wb_index == issue_rd)));

    assign issue_fire = issue_valid && issue_ready && !flush &&
                        in_range(issue_rd) && (issue_rd != 5'd0);

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_reg
            if ((gi != 0) && (gi < NUM_REGS)) begin : g_live
                localparam logic [4:0] IDX = 5'(gi);
                logic [XLEN-1:0]   data_reg;
                logic [PEND_W-1:0] cnt_reg;
                logic              inc;
                logic              dec;

                assign inc = issue_fire && (issue_rd == IDX);
                assign dec = wb_fire && (wb_index == IDX);

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        data_reg <= '0;
                        cnt_reg  <= '0;
                    end else begin
                        if (dec) begin
                            data_reg <= wb_data;
                        end
                        if (flush) begin
                            cnt_reg <= '0;
                        end else if (inc && !dec) begin
                            cnt_reg <= cnt_reg + CNT_ONE;
                        end else if (dec && !inc && (cnt_reg != '0)) begin
                            cnt_reg <= cnt_reg - CNT_ONE;
                        end
                    end
                end

                assign reg_view[gi] = data_reg;
                assign cnt_view[gi] = cnt_reg;
            end else begin : g_zero
                assign reg_view[gi] = '0;
                assign cnt_view[gi] = '0;
            end
        end
    endgenerate

    // wb_fire already excludes x0 and out-of-range indices, so a hit only
    // ever forwards to a real register.
    assign rs1_hit = (BYPASS != 0) && wb_fire && (wb_index == rs1_index);
    assign rs2_hit = (BYPASS != 0) && wb_fire && (wb_index == rs2_index);

    assign rs1_data = rs1_hit ? wb_data : reg_view[rs1_index];
    assign rs2_data = rs2_hit ? wb_data : reg_view[rs2_index];

    // The last outstanding writer retiring in this cycle is forwarded, so the
    // consumer need not wait for it.
    assign rs1_busy = (cnt_view[rs1_index] != '0) &&
                      !(rs1_hit && (cnt_view[rs1_index] == CNT_ONE));
    assign rs2_busy = (cnt_view[rs2_index] != '0) &&
                      !(rs2_hit && (cnt_view[rs2_index] == CNT_ONE));

    assign illegal_index = !in_range(rs1_index) ||
                           !in_range(rs2_index) ||
                           (issue_valid && !in_range(issue_rd)) ||
                           (wb_valid && !in_range(wb_index));

    logic [XLEN-1:0] pc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg <= RESET_PC;
        end else if (pc_write_enable) begin
            pc_reg <= pc_write_data;
        end
    end

    assign pc_read_data = pc_reg;

`ifdef GPR_DEBUG_PORT_EN
    assign dbg_data    = reg_view[dbg_index];
    assign dbg_pending = cnt_view[dbg_index];
`endif

endmodule

// File: tb/tb_gpr_file_scoreboard.sv
// Testbench for gpr_file_scoreboard.
// Two instances share one stimulus stream: the main one is RV32E with
// bypass (RESET_PC 8000_0000), the second is RV32I without bypass
// (RESET_PC 0000_1000). Vectors are table-driven; expected values travel
// through a scoreboard queue and are compared on the falling edge.

module tb_gpr_file_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_index, rs2_index, issue_rd, wb_index;
    logic        issue_valid, wb_valid, flush, pc_write_enable;
    logic [31:0] wb_data, pc_write_data;

    logic [31:0] rs1_data, rs2_data, pc_read_data;
    logic        rs1_busy, rs2_busy, issue_ready, illegal_index;

    logic [31:0] b_rs1_data, b_rs2_data, b_pc_read_data;
    logic        b_rs1_busy, b_rs2_busy, b_issue_ready, b_illegal_index;

    always #5 clk = ~clk;

    gpr_file_scoreboard #(
        .XLEN(32), .NUM_REGS(16), .PEND_W(2), .BYPASS(1), .RESET_PC(32'h8000_0000)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_index(rs1_index), .rs1_data(rs1_data), .rs1_busy(rs1_busy),
        .rs2_index(rs2_index), .rs2_data(rs2_data), .rs2_busy(rs2_busy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_index(wb_index), .wb_data(wb_data),
        .flush(flush), .illegal_index(illegal_index),
        .pc_read_data(pc_read_data), .pc_write_data(pc_write_data),
        .pc_write_enable(pc_write_enable)
    );

    gpr_file_scoreboard #(
        .XLEN(32), .NUM_REGS(32), .PEND_W(2), .BYPASS(0), .RESET_PC(32'h0000_1000)
    ) dut_b0 (
        .clk(clk), .rst_n(rst_n),
        .rs1_index(rs1_index), .rs1_data(b_rs1_data), .rs1_busy(b_rs1_busy),
        .rs2_index(rs2_index), .rs2_data(b_rs2_data), .rs2_busy(b_rs2_busy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(b_issue_ready),
        .wb_valid(wb_valid), .wb_index(wb_index), .wb_data(wb_data),
        .flush(flush), .illegal_index(b_illegal_index),
        .pc_read_data(b_pc_read_data), .pc_write_data(pc_write_data),
        .pc_write_enable(pc_write_enable)
    );

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic        iv;
        logic [4:0]  ird;
        logic        wv;
        logic [4:0]  wi;
        logic [31:0] wd;
        logic        fl;
        logic [31:0] r1d;
        logic        r1b;
        logic [31:0] r2d;
        logic        r2b;
        logic        rdy;
        logic        ill;
        logic [31:0] b_r1d;
        logic        b_r1b;
        logic        b_ill;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];
    vec_t sb [$];

    int errors = 0;
    int checks = 0;

    function automatic vec_t mk(
        input int rs1, input int rs2, input int iv, input int ird,
        input int wv, input int wi, input logic [31:0] wd, input int fl,
        input logic [31:0] r1d, input int r1b, input logic [31:0] r2d, input int r2b,
        input int rdy, input int ill,
        input logic [31:0] b_r1d, input int b_r1b, input int b_ill);
        vec_t v;
        v.rs1 = 5'(rs1);  v.rs2 = 5'(rs2);
        v.iv = 1'(iv);    v.ird = 5'(ird);
        v.wv = 1'(wv);    v.wi = 5'(wi);   v.wd = wd;   v.fl = 1'(fl);
        v.r1d = r1d;      v.r1b = 1'(r1b);
        v.r2d = r2d;      v.r2b = 1'(r2b);
        v.rdy = 1'(rdy);  v.ill = 1'(ill);
        v.b_r1d = b_r1d;  v.b_r1b = 1'(b_r1b); v.b_ill = 1'(b_ill);
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic idle();
        rs1_index = 5'd0; rs2_index = 5'd0;
        issue_valid = 1'b0; issue_rd = 5'd0;
        wb_valid = 1'b0; wb_index = 5'd0; wb_data = 32'h0;
        flush = 1'b0; pc_write_enable = 1'b0; pc_write_data = 32'h0;
    endtask

    initial begin
        // rs1 rs2 iv ird wv wi wd fl | r1d r1b r2d r2b rdy ill | b_r1d b_r1b b_ill
        vecs[0]  = mk(5, 0, 0, 0, 1, 5, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 0, 0, 1, 0, 0, 0, 0);
        vecs[1]  = mk(5, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 0, 0);
        vecs[2]  = mk(0, 5, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 32'hDEAD_BEEF, 0, 1, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        vecs[4]  = mk(7, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        vecs[5]  = mk(7, 0, 1, 7, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0);
        vecs[6]  = mk(7, 0, 1, 7, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0);
        vecs[7]  = mk(7, 0, 1, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        vecs[8]  = mk(7, 0, 0, 7, 1, 7, 32'h77, 0, 32'h77, 1, 0, 0, 1, 0, 0, 1, 0);
        vecs[9]  = mk(7, 0, 0, 7, 1, 7, 32'h78, 0, 32'h78, 1, 0, 0, 1, 0, 32'h77, 1, 0);
        vecs[10] = mk(7, 0, 0, 7, 1, 7, 32'h79, 0, 32'h79, 0, 0, 0, 1, 0, 32'h78, 1, 0);
        vecs[11] = mk(7, 0, 0, 7, 0, 0, 0, 0, 32'h79, 0, 0, 0, 1, 0, 32'h79, 0, 0);
        vecs[12] = mk(3, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        vecs[13] = mk(3, 0, 1, 3, 1, 3, 32'h33, 0, 32'h33, 0, 0, 0, 1, 0, 0, 1, 0);
        vecs[14] = mk(3, 0, 0, 0, 0, 0, 0, 0, 32'h33, 1, 0, 0, 1, 0, 32'h33, 1, 0);
        vecs[15] = mk(4, 3, 0, 0, 1, 4, 32'h44, 0, 32'h44, 0, 32'h33, 1, 1, 0, 0, 0, 0);
        vecs[16] = mk(4, 0, 0, 0, 0, 0, 0, 0, 32'h44, 0, 0, 0, 1, 0, 32'h44, 0, 0);
        vecs[17] = mk(20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        vecs[18] = mk(20, 0, 0, 0, 1, 20, 32'h2020, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        vecs[19] = mk(20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h2020, 0, 0);
        vecs[20] = mk(0, 0, 1, 20, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        vecs[21] = mk(0, 0, 0, 20, 0, 20, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        vecs[22] = mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        vecs[23] = mk(1, 2, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0);
        vecs[24] = mk(1, 2, 1, 9, 1, 6, 32'h66, 1, 0, 1, 0, 1, 1, 0, 0, 1, 0);
        vecs[25] = mk(9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        vecs[26] = mk(6, 3, 0, 0, 0, 0, 0, 0, 32'h66, 0, 32'h33, 0, 1, 0, 32'h66, 0, 0);

        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        chk("reset_pc", -1, pc_read_data, 32'h8000_0000);
        chk("reset_pc_b0", -1, b_pc_read_data, 32'h0000_1000);
        chk("reset_rs1_data", -1, rs1_data, 32'h0);
        chk("reset_rs2_data", -1, rs2_data, 32'h0);
        chk("reset_rs1_busy", -1, 32'(rs1_busy), 32'h0);
        chk("reset_rs2_busy", -1, 32'(rs2_busy), 32'h0);
        chk("reset_issue_ready", -1, 32'(issue_ready), 32'h1);
        $display("reset: pc=%h b0_pc=%h", pc_read_data, b_pc_read_data);

        @(posedge clk);
        for (int i = 0; i < NV; i++) begin
            vec_t e;
            #1;
            rs1_index = vecs[i].rs1; rs2_index = vecs[i].rs2;
            issue_valid = vecs[i].iv; issue_rd = vecs[i].ird;
            wb_valid = vecs[i].wv; wb_index = vecs[i].wi; wb_data = vecs[i].wd;
            flush = vecs[i].fl;
            sb.push_back(vecs[i]);
            @(negedge clk);
            e = sb.pop_front();
            chk("rs1_data", i, rs1_data, e.r1d);
            chk("rs1_busy", i, 32'(rs1_busy), 32'(e.r1b));
            chk("rs2_data", i, rs2_data, e.r2d);
            chk("rs2_busy", i, 32'(rs2_busy), 32'(e.r2b));
            chk("issue_ready", i, 32'(issue_ready), 32'(e.rdy));
            chk("illegal_index", i, 32'(illegal_index), 32'(e.ill));
            chk("b0_rs1_data", i, b_rs1_data, e.b_r1d);
            chk("b0_rs1_busy", i, 32'(b_rs1_busy), 32'(e.b_r1b));
            chk("b0_illegal_index", i, 32'(b_illegal_index), 32'(e.b_ill));
            $display("vec %0d: rs1=%0d data=%h busy=%0d rs2=%0d data=%h busy=%0d rdy=%0d ill=%0d",
                     i, rs1_index, rs1_data, rs1_busy, rs2_index, rs2_data, rs2_busy,
                     issue_ready, illegal_index);
            @(posedge clk);
        end

        // PC load, then hold while flush is active
        #1;
        idle();
        pc_write_enable = 1'b1; pc_write_data = 32'h1234_5678;
        @(negedge clk);
        chk("pc_before_load", 100, pc_read_data, 32'h8000_0000);
        @(posedge clk);
        #1;
        pc_write_enable = 1'b0; pc_write_data = 32'hFFFF_FFFF; flush = 1'b1;
        @(negedge clk);
        chk("pc_after_load", 101, pc_read_data, 32'h1234_5678);
        chk("pc_after_load_b0", 101, b_pc_read_data, 32'h1234_5678);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("pc_hold", 102, pc_read_data, 32'h1234_5678);
        $display("pc sequence: pc=%h", pc_read_data);

        // Reserve x5, then assert reset asynchronously mid-cycle
        @(posedge clk);
        #1;
        issue_valid = 1'b1; issue_rd = 5'd5; rs1_index = 5'd5;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_busy", 103, 32'(rs1_busy), 32'h1);
        chk("pre_reset_data", 103, rs1_data, 32'hDEAD_BEEF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_data", 104, rs1_data, 32'h0);
        chk("async_reset_busy", 104, 32'(rs1_busy), 32'h0);
        chk("async_reset_pc", 104, pc_read_data, 32'h8000_0000);
        chk("async_reset_pc_b0", 104, b_pc_read_data, 32'h0000_1000);
        chk("async_reset_ready", 104, 32'(issue_ready), 32'h1);
        $display("mid reset: rs1_data=%h busy=%0d pc=%h", rs1_data, rs1_busy, pc_read_data);
        issue_valid = 1'b1; issue_rd = 5'd5;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue_valid = 1'b0;
        #1;
        chk("post_reset_busy", 105, 32'(rs1_busy), 32'h0);
        chk("post_reset_data", 105, rs1_data, 32'h0);
        $display("post reset: rs1_data=%h busy=%0d", rs1_data, rs1_busy);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
